data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder serving load/store requests from the MEM stage of the pipelined datapath.
- The MEM stage is the initiator. This block accepts one request at a time over a valid/ready handshake, models a fixed access latency, and returns read data with a one-cycle response pulse.
- It provides byte, half and word access with sign/zero extension, plus an out-of-range error flag, so the pipeline hazard logic can stall on busy.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words of storage; power of two.
- LATENCY, 2, wait cycles between request accept and data commit/return; 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_signed  input  1  loads only: 1 = sign-extend byte/half, 0 = zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; byte/half taken from low bits.
- resp_valid  output  1  one-cycle pulse; response data valid.
- resp_rdata  output  32  load result (0 for stores and errors).
- resp_err  output  1  qualified by resp_valid; access faulted.
- busy  output  1  high from accept until the cycle after resp_valid.

Behaviour:
- Reset (rst=0, immediate): state IDLE, req_ready=1 once released, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, wait counter=0.
- Reset mid-operation discards the pending request and drops any uncommitted store. Storage contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write/size/signed/addr/wdata, load counter=LATENCY, set busy=1.
  - LATENCY=0 goes directly to RESP; otherwise go to WAIT.
- WAIT: req_ready=0. Decrement counter each cycle; when counter reaches 1, commit the access and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, with resp_rdata/resp_err registered. req_ready=0. Next state is IDLE with busy=0.
- Latency: accept at edge N gives resp_valid high in cycle N+LATENCY+1. Maximum throughput is one request per LATENCY+2 cycles.
- Requests presented while req_ready=0 are ignored. The initiator holds req_valid and its fields until accepted.
- Addressing: word index = req_addr[31:2]; little-endian byte lanes in the word.
  - Byte lane = addr[1:0].
  - Half lane = addr[1]; without the optional feature, addr[0] is ignored.
  - Word: addr[1:0] ignored.
- Out of range (word index >= DEPTH_WORDS): store dropped, resp_rdata=0, resp_err=1. This check is always compiled in.
- Stores write only the selected lanes; other bytes are preserved. Store responses return resp_rdata=0, resp_err=0.
- Loads: extract the lane, then sign- or zero-extend to 32 bits per req_signed. Word loads ignore req_signed.
- Storage is uninitialised apart from writes; the bench must write before reading.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- When defined, a misaligned request faults: half with addr[0]=1, or word/size 11 with addr[1:0]!=0. The fault gives resp_err=1, resp_rdata=0, store suppressed, with the same latency as a normal access.
- When undefined, low address bits are ignored per size (forced alignment) and resp_err reflects only out-of-range.

Test Plan:
- Reset then word store addr 0x10 data 0xDEADBEEF, LATENCY=2 -> resp_valid exactly 3 cycles after accept, resp_err=0. A word load from 0x10 then returns 0xDEADBEEF.
- Byte store 0x7F to 0x11 over word 0x00000000, then signed byte load 0x11 -> 0x0000007F. Store 0x80 to 0x13, then signed byte load 0x13 -> 0xFFFFFF80, unsigned -> 0x00000080, word load 0x10 -> 0x80007F00.
- Half store 0xBEEF to 0x22 over 0x11111111 -> word 0xBEEF1111. Signed half load 0x22 -> 0xFFFFBEEF.
- Word load at 0x00001000 with DEPTH_WORDS=1024 -> resp_err=1, resp_rdata=0. Store to the same address leaves word 0 unchanged.
- Assert rst=0 one cycle after accepting a store to 0x20 (LATENCY=2) -> no resp_valid, word 0x20 unchanged, req_ready=1 after release. Hold req_valid during WAIT -> second request accepted only in the IDLE cycle after RESP.
- With DMEM_ALIGN_CHECK_EN, word load at 0x12 -> resp_err=1, resp_rdata=0. Without it, the same load returns the word at 0x10, resp_err=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle load/store data-memory responder (optional macro DMEM_ALIGN_CHECK_EN)
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_d;
  logic        lat_write, lat_signed;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr, lat_wdata;
  logic [31:0] rdata_d;
  logic        err_d;
  logic        accept, commit, we;

  logic        acc_write, acc_signed;
  logic [1:0]  acc_size;
  logic [31:0] acc_addr, acc_wdata;
  logic [IDX_W-1:0] idx;
  logic        oor, misalign, fault;
  logic [31:0] rd_word, ld_data, st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  st_be;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign accept     = req_valid && req_ready;

  // Access fields: live request when committing straight from IDLE (zero latency), latched copy otherwise
  always_comb begin
    if (state_q == IDLE) begin
      acc_write  = req_write;
      acc_size   = req_size;
      acc_signed = req_signed;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
    end else begin
      acc_write  = lat_write;
      acc_size   = lat_size;
      acc_signed = lat_signed;
      acc_addr   = lat_addr;
      acc_wdata  = lat_wdata;
    end
  end

  assign idx     = acc_addr[IDX_W+1:2];
  assign oor     = (acc_addr[31:2] >= 30'(DEPTH_WORDS));
  assign rd_word = mem[idx];

  // Fault detection, load lane extraction/extension and store lane placement
  always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
    misalign = ((acc_size == 2'b01) && acc_addr[0]) ||
               (acc_size[1] && (acc_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    fault = oor || misalign;

    case (acc_addr[1:0])
      2'b00:   ld_byte = rd_word[7:0];
      2'b01:   ld_byte = rd_word[15:8];
      2'b10:   ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

    case (acc_size)
      2'b00: begin
        ld_data = acc_signed ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
        st_be   = 4'b0001 << acc_addr[1:0];
        st_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        ld_data = acc_signed ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
        st_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        ld_data = rd_word;
        st_be   = 4'b1111;
        st_data = acc_wdata;
      end
    endcase
  end

  // Next-state, wait counter, busy and response data for the IDLE/WAIT/RESP sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q_get();
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          busy_d = 1'b1;
          cnt_d  = 4'(LATENCY);
          if (LATENCY == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    rdata_d = (commit && !acc_write && !fault) ? ld_data : 32'd0;
    err_d   = commit && fault;
  end

  assign we = commit && acc_write && !fault && rst;

  function automatic logic busy_q_get();
    return busy;
  endfunction

  // Control state, request latch and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      busy       <= 1'b0;
      lat_write  <= 1'b0;
      lat_size   <= 2'b00;
      lat_signed <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy       <= busy_d;
      resp_rdata <= rdata_d;
      resp_err   <= err_d;
      if (accept) begin
        lat_write  <= req_write;
        lat_size   <= req_size;
        lat_signed <= req_signed;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
      end
    end
  end

  // Storage: byte-lane writes at commit, never cleared by reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

endmodule
